// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and GF(2^8) helpers for the AES key schedule
package aes_pkg;

  localparam logic [7:0] rcon_init_lp = 8'h01;
  localparam logic [7:0] rcon_poly_lp = 8'h1b;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE, ZERO} state_e;
  typedef enum logic [1:0] {MODE_PLAIN, MODE_SUB, MODE_ROT_SUB} word_mode_e;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_rk_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? rcon_poly_lp : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// rtl/aes_key_word_gen.sv - combinational single-step key schedule word w[i] from w[i-1] and w[i-nk]
module aes_key_word_gen
  import aes_pkg::*;
(
  input  aes_word_t  prev_i,
  input  aes_word_t  back_i,
  input  logic [7:0] rcon_i,
  input  word_mode_e mode_i,
  output aes_word_t  word_o
);

  aes_word_t rot;
  aes_word_t sub;
  aes_word_t temp;

  assign rot = (mode_i == MODE_ROT_SUB) ? {prev_i[23:0], prev_i[31:24]} : prev_i;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    rom_sbox u_sbox (
      .a_i(rot[8*b +: 8]),
      .s_o(sub[8*b +: 8])
    );
  end

  always_comb begin
    temp = prev_i;
    case (mode_i)
      MODE_SUB:     temp = sub;
      MODE_ROT_SUB: temp = sub ^ {rcon_i, 24'h0};
      default:      temp = prev_i;
    endcase
    word_o = back_i ^ temp;
  end

endmodule

// File: rtl/rom_sbox.sv
// rtl/rom_sbox.sv - AES forward S-box lookup (inverse in GF(2^8) followed by the affine map)
module rom_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // a^254 is the multiplicative inverse; 0 maps to 0 as required
  always_comb begin
    x2   = gf_mul(a_i, a_i);
    x3   = gf_mul(x2, a_i);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128/256 key schedule, one word per cycle, round-key table
// Optional zeroize state and port enabled by AES_KEY_ZEROIZE_EN.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int key_bits_p = 256
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                  zeroize_i,
`endif
  input  logic [key_bits_p-1:0] key_i,
  input  logic                  v_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [3:0]            rounds_valid_o,
  input  logic [3:0]            rk_addr_i,
  output logic [127:0]          rk_data_o,
  output logic                  rk_v_o
);

  localparam int nk_lp = key_bits_p / 32;
  localparam int nr_lp = nk_lp + 6;
  localparam int nw_lp = 4 * (nr_lp + 1);

  localparam logic [3:0] nr_l      = 4'(nr_lp);
  localparam logic [3:0] rv_load_l = 4'(nk_lp / 4);
  localparam logic [5:0] last_l    = 6'(nw_lp - 1);
  localparam logic [5:0] nk_mask_l = 6'(nk_lp - 1);

  if (key_bits_p != 128 && key_bits_p != 256) begin : g_bad_key_bits
    $error("aes_key_expand_seq: key_bits_p must be 128 or 256");
  end

  state_e     state_q, state_d;
  logic [5:0] idx_q;
  logic [7:0] rcon_q;
  logic [3:0] rounds_valid_q;
  aes_rk_t    rk_data_q;
  logic       rk_v_q;
  aes_word_t  win_q [nk_lp];
  aes_rk_t    tbl_q [nr_lp+1];

  word_mode_e mode;
  aes_word_t  new_word;
  logic       zero_req, load, step, zstep;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero_req = zeroize_i;
`else
  assign zero_req = 1'b0;
`endif

  assign load  = ready_o & v_i & ~zero_req & ~reset_i;
  assign step  = (state_q == EXPAND) & ~zero_req & ~reset_i;
  assign zstep = (state_q == ZERO) & ~zero_req & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) state_d = EXPAND;
      end
      EXPAND: if (idx_q == last_l) state_d = DONE;
      DONE: begin
        ready_o = 1'b1;
        done_o  = 1'b1;
        if (v_i) state_d = EXPAND;
      end
`ifdef AES_KEY_ZEROIZE_EN
      ZERO: if (idx_q == {2'b00, nr_l}) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    if (zero_req) state_d = ZERO;
  end

  // rot+sub+rcon on every nk-th word; AES-256 adds a sub-only step halfway through each group
  always_comb begin
    mode = MODE_PLAIN;
    if ((idx_q & nk_mask_l) == 6'd0)             mode = MODE_ROT_SUB;
    else if (nk_lp == 8 && idx_q[2:0] == 3'd4)   mode = MODE_SUB;
  end

  aes_key_word_gen u_word_gen (
    .prev_i(win_q[nk_lp-1]),
    .back_i(win_q[0]),
    .rcon_i(rcon_q),
    .mode_i(mode),
    .word_o(new_word)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q          <= '0;
      rcon_q         <= rcon_init_lp;
      rounds_valid_q <= '0;
      rk_data_q      <= '0;
      rk_v_q         <= 1'b0;
    end else begin
      rk_v_q    <= (rk_addr_i < rounds_valid_q);
      rk_data_q <= (rk_addr_i <= nr_l) ? tbl_q[rk_addr_i] : '0;
      if (zero_req) begin
        idx_q          <= '0;
        rcon_q         <= 8'h00;
        rounds_valid_q <= '0;
      end else if (load) begin
        idx_q          <= 6'(nk_lp);
        rcon_q         <= rcon_init_lp;
        rounds_valid_q <= rv_load_l;
      end else if (step) begin
        idx_q <= idx_q + 6'd1;
        if (mode == MODE_ROT_SUB) rcon_q <= xtime(rcon_q);
        if (idx_q[1:0] == 2'b11)  rounds_valid_q <= rounds_valid_q + 4'd1;
      end else if (zstep) begin
        idx_q <= idx_q + 6'd1;
      end
    end
  end

  // Window and table carry no reset; rounds_valid gates every read
  always_ff @(posedge clk_i) begin
    if (zero_req) begin
      for (int j = 0; j < nk_lp; j++) win_q[j] <= '0;
    end else if (load) begin
      for (int j = 0; j < nk_lp; j++)     win_q[j] <= key_i[key_bits_p-1-32*j -: 32];
      for (int r = 0; r < nk_lp / 4; r++) tbl_q[r] <= key_i[key_bits_p-1-128*r -: 128];
    end else if (step) begin
      for (int j = 0; j < nk_lp - 1; j++) win_q[j] <= win_q[j+1];
      win_q[nk_lp-1] <= new_word;
      tbl_q[idx_q[5:2]][{~idx_q[1:0], 5'b00000} +: 32] <= new_word;
    end else if (zstep) begin
      tbl_q[idx_q[3:0]] <= '0;
    end
  end

  assign rounds_valid_o = rounds_valid_q;
  assign rk_data_o      = rk_data_q;
  assign rk_v_o         = rk_v_q;

endmodule
